// File: rtl/scroll_sequencer.sv
// scroll_sequencer: paints NUM_ROWS text rows one at a time, holds the frame,
// then scrolls the row RAMs by one position and repeats while enable is high.
// The start and hold delays are timed by an internal counter.
// Optional feature macro: SCROLL_PAUSE_EN adds a pause input that freezes
// sequencing. Without it there is no pause port.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | game mode inactive, all outputs low
// START_DLY | initial instruction delay, START_CYCLES cycles
// RST_DRAW  | one-cycle restart pulse before drawing row row_idx
// DRAW      | draw engine row_idx running, wait for its finish_draw bit
// HOLD      | frame held on screen, HOLD_CYCLES cycles
// RST_UPD   | one-cycle restart pulse before update step row_idx (load on 0)
// UPD       | row RAM update step row_idx, wait for finish_update
module scroll_sequencer #(
  parameter int NUM_ROWS     = 4,
  parameter int DELAY_W      = 26,
  parameter int START_CYCLES = 50000000,
  parameter int HOLD_CYCLES  = 25000000,
  parameter int SEL_W        = 3,
  parameter int UPD_SEL      = 5,
  parameter int FRAME_W      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_ROWS-1:0]         finish_draw,
  input  logic                        finish_update,
`ifdef SCROLL_PAUSE_EN
  input  logic                        pause,
`endif
  output logic                        restart,
  output logic [NUM_ROWS-1:0]         draw,
  output logic                        delay_active,
  output logic                        load,
  output logic                        update,
  output logic [NUM_ROWS-1:0]         wren,
  output logic [NUM_ROWS-2:0]         shift,
  output logic [SEL_W-1:0]            display_select,
  output logic [SEL_W-1:0]            colour_select,
  output logic [$clog2(NUM_ROWS)-1:0] row_idx,
  output logic [FRAME_W-1:0]          frame_count
);

  localparam int ROW_W = $clog2(NUM_ROWS);

  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(NUM_ROWS - 1);
  localparam logic [DELAY_W-1:0] START_LAST = DELAY_W'(START_CYCLES - 1);
  localparam logic [DELAY_W-1:0] HOLD_LAST  = DELAY_W'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0]   SEL_UPD    = SEL_W'(UPD_SEL);
  localparam logic [SEL_W-1:0]   SEL_HOLD   = SEL_W'(NUM_ROWS);

  typedef enum logic [2:0] {
    IDLE,
    START_DLY,
    RST_DRAW,
    DRAW,
    HOLD,
    RST_UPD,
    UPD
  } state_t;

  state_t               state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [DELAY_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;

  logic                 restart_q, restart_d;
  logic [NUM_ROWS-1:0]  draw_q, draw_d;
  logic                 delay_active_q, delay_active_d;
  logic                 load_q, load_d;
  logic                 update_q, update_d;
  logic [NUM_ROWS-1:0]  wren_q, wren_d;
  logic [NUM_ROWS-2:0]  shift_q, shift_d;
  logic [SEL_W-1:0]     dsel_q, dsel_d;
  logic [SEL_W-1:0]     csel_q, csel_d;

  logic                 pause_w;

`ifdef SCROLL_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // Next state, row index, delay counter and frame counter.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if ((state_q != IDLE) && !enable) begin
      // Abort beats any finish_* arriving in the same cycle.
      state_d = IDLE;
      row_d   = '0;
      cnt_d   = '0;
    end else if (!pause_w) begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_d = START_DLY;
            row_d   = '0;
            cnt_d   = '0;
          end
        end
        START_DLY: begin
          if (cnt_q == START_LAST) begin
            state_d = RST_DRAW;
            row_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DELAY_W'(1);
          end
        end
        RST_DRAW: state_d = DRAW;
        DRAW: begin
          // Only the engine of the row being drawn can advance the sequence.
          if (finish_draw[row_q]) begin
            if (row_q == LAST_ROW) begin
              state_d = HOLD;
              cnt_d   = '0;
            end else begin
              row_d   = row_q + ROW_W'(1);
              state_d = RST_DRAW;
            end
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = RST_UPD;
            row_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DELAY_W'(1);
          end
        end
        RST_UPD: state_d = UPD;
        UPD: begin
          if (finish_update) begin
            if (row_q == LAST_ROW) begin
              frame_d = frame_q + FRAME_W'(1);
              row_d   = '0;
              state_d = RST_DRAW;
            end else begin
              row_d   = row_q + ROW_W'(1);
              state_d = RST_UPD;
            end
          end
        end
        default: begin
          state_d = IDLE;
          row_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore outputs decoded from the next state so they register in step with it.
  always_comb begin
    restart_d      = 1'b0;
    draw_d         = '0;
    delay_active_d = 1'b0;
    load_d         = 1'b0;
    update_d       = 1'b0;
    wren_d         = '0;
    shift_d        = '0;
    dsel_d         = '0;
    csel_d         = '0;
    case (state_d)
      START_DLY: delay_active_d = 1'b1;
      RST_DRAW: begin
        restart_d = 1'b1;
        dsel_d    = SEL_W'(1);
        // Row 0 has no predecessor colour, so it shows colour 1 early.
        csel_d    = (row_d == '0) ? SEL_W'(1) : SEL_W'(row_d);
      end
      DRAW: begin
        draw_d = NUM_ROWS'(1) << row_d;
        dsel_d = SEL_W'(1);
        csel_d = SEL_W'(row_d) + SEL_W'(1);
      end
      HOLD: begin
        delay_active_d = 1'b1;
        dsel_d         = SEL_W'(1);
        csel_d         = SEL_HOLD;
      end
      RST_UPD: begin
        restart_d = 1'b1;
        load_d    = (row_d == '0);
        dsel_d    = SEL_UPD;
        csel_d    = SEL_UPD;
      end
      UPD: begin
        update_d = 1'b1;
        // Rows are rewritten bottom-up: each takes the row above it, and the
        // top row finally takes the freshly loaded text (no shift source).
        wren_d   = NUM_ROWS'(1) << (LAST_ROW - row_d);
        if (row_d != LAST_ROW) begin
          shift_d = (NUM_ROWS-1)'(1) << (LAST_ROW - ROW_W'(1) - row_d);
        end
        dsel_d   = SEL_UPD;
        csel_d   = SEL_UPD;
      end
      default: begin
        restart_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      row_q          <= '0;
      cnt_q          <= '0;
      frame_q        <= '0;
      restart_q      <= 1'b0;
      draw_q         <= '0;
      delay_active_q <= 1'b0;
      load_q         <= 1'b0;
      update_q       <= 1'b0;
      wren_q         <= '0;
      shift_q        <= '0;
      dsel_q         <= '0;
      csel_q         <= '0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      cnt_q          <= cnt_d;
      frame_q        <= frame_d;
      restart_q      <= restart_d;
      draw_q         <= draw_d;
      delay_active_q <= delay_active_d;
      load_q         <= load_d;
      update_q       <= update_d;
      wren_q         <= wren_d;
      shift_q        <= shift_d;
      dsel_q         <= dsel_d;
      csel_q         <= csel_d;
    end
  end

  // Pause masks the engine restart and text load immediately; everything
  // else simply holds because the state is frozen.
  assign restart        = restart_q & ~pause_w;
  assign load           = load_q & ~pause_w;
  assign draw           = draw_q;
  assign delay_active   = delay_active_q;
  assign update         = update_q;
  assign wren           = wren_q;
  assign shift          = shift_q;
  assign display_select = dsel_q;
  assign colour_select  = csel_q;
  assign row_idx        = row_q;
  assign frame_count    = frame_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Directed testbench for scroll_sequencer (NUM_ROWS=4, START=3, HOLD=2).
// Build with SCROLL_PAUSE_EN defined to also exercise the pause feature.
module tb_scroll_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] finish_draw;
  logic       finish_update;
  logic       pause;
  logic       restart;
  logic [3:0] draw;
  logic       delay_active;
  logic       load;
  logic       update;
  logic [3:0] wren;
  logic [2:0] shift;
  logic [2:0] display_select;
  logic [2:0] colour_select;
  logic [1:0] row_idx;
  logic [7:0] frame_count;

  int vectors = 0;
  int errors  = 0;

  scroll_sequencer #(
    .NUM_ROWS(4), .DELAY_W(4), .START_CYCLES(3), .HOLD_CYCLES(2),
    .SEL_W(3), .UPD_SEL(5), .FRAME_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .finish_draw(finish_draw),
    .finish_update(finish_update),
`ifdef SCROLL_PAUSE_EN
    .pause(pause),
`endif
    .restart(restart),
    .draw(draw),
    .delay_active(delay_active),
    .load(load),
    .update(update),
    .wren(wren),
    .shift(shift),
    .display_select(display_select),
    .colour_select(colour_select),
    .row_idx(row_idx),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares every control output at once:
  // {restart, draw, delay_active, load, update, wren, shift, display, colour}
  task automatic chk_o(input string tag, input logic rs, input logic [3:0] dr,
                       input logic da, input logic ld, input logic up,
                       input logic [3:0] wr, input logic [2:0] sh,
                       input logic [2:0] ds, input logic [2:0] cs);
    logic [20:0] obs, exp;
    obs = {restart, draw, delay_active, load, update, wren, shift, display_select, colour_select};
    exp = {rs, dr, da, ld, up, wr, sh, ds, cs};
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic chk_idle(input string tag);
    chk_o(tag, 0, 4'b0000, 0, 0, 0, 4'b0000, 3'b000, 3'd0, 3'd0);
    chk({tag, "_row"}, 32'(row_idx), 32'd0);
  endtask

  // Expects to be in START_DLY's first cycle; ends in RST_DRAW row 0.
  task automatic run_start();
    for (int i = 0; i < 3; i++) begin
      chk_o("start_dly", 0, 4'b0000, 1, 0, 0, 4'b0000, 3'b000, 3'd0, 3'd0);
      tick();
    end
  endtask

  // Expects RST_DRAW row 0; ends in the first HOLD cycle.
  task automatic run_draws(input bit stray);
    logic [3:0] onehot;
    logic [2:0] rst_col;
    for (int i = 0; i < 4; i++) begin
      onehot  = 4'b0001 << i;
      rst_col = (i == 0) ? 3'd1 : 3'(i);
      chk_o("rst_draw", 1, 4'b0000, 0, 0, 0, 4'b0000, 3'b000, 3'd1, rst_col);
      chk("rst_draw_row", 32'(row_idx), 32'(i));
      tick();
      chk_o("draw", 0, onehot, 0, 0, 0, 4'b0000, 3'b000, 3'd1, 3'(i + 1));
      if (stray && i == 0) begin
        finish_draw = 4'b0100;
        tick();
        chk_o("stray_finish", 0, 4'b0001, 0, 0, 0, 4'b0000, 3'b000, 3'd1, 3'd1);
      end
      finish_draw = onehot;
      tick();
      finish_draw = 4'b0000;
    end
  endtask

  // Expects RST_UPD row 0. With abort_last, the last step sees finish_update
  // together with enable falling and must land in IDLE.
  task automatic run_updates(input bit abort_last);
    logic [3:0] exp_wren;
    logic [2:0] exp_shift;
    for (int j = 0; j < 4; j++) begin
      exp_wren  = 4'b1000 >> j;
      exp_shift = (j < 3) ? (3'b100 >> j) : 3'b000;
      chk_o("rst_upd", 1, 4'b0000, 0, (j == 0), 0, 4'b0000, 3'b000, 3'd5, 3'd5);
      tick();
      chk_o("upd", 0, 4'b0000, 0, 0, 1, exp_wren, exp_shift, 3'd5, 3'd5);
      chk("upd_row", 32'(row_idx), 32'(j));
      finish_update = 1'b1;
      if (abort_last && j == 3) enable = 1'b0;
      tick();
      finish_update = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; finish_draw = '0; finish_update = 1'b0; pause = 1'b0;
    tick(); tick();
    chk_idle("reset");
    chk("reset_frame", 32'(frame_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle("idle_no_enable");
    end

    // Full frame: start delay, draws, hold, update.
    enable = 1'b1;
    tick();
    run_start();
    run_draws(1'b1);
    for (int i = 0; i < 2; i++) begin
      chk_o("hold", 0, 4'b0000, 1, 0, 0, 4'b0000, 3'b000, 3'd1, 3'd4);
      tick();
    end
    chk("frame_before", 32'(frame_count), 32'd0);
    run_updates(1'b0);
    chk_o("wrap_rst_draw", 1, 4'b0000, 0, 0, 0, 4'b0000, 3'b000, 3'd1, 3'd1);
    chk("frame_after", 32'(frame_count), 32'd1);
    chk("wrap_row", 32'(row_idx), 32'd0);

    // Abort in DRAW, then full-length restart.
    tick();
    chk_o("draw_before_abort", 0, 4'b0001, 0, 0, 0, 4'b0000, 3'b000, 3'd1, 3'd1);
    enable = 1'b0;
    tick();
    chk_idle("abort_draw");
    chk("abort_frame_kept", 32'(frame_count), 32'd1);
    enable = 1'b1;
    tick();
    run_start();
    run_draws(1'b0);

    // Abort in HOLD, then full-length restart.
    chk_o("hold_before_abort", 0, 4'b0000, 1, 0, 0, 4'b0000, 3'b000, 3'd1, 3'd4);
    enable = 1'b0;
    tick();
    chk_idle("abort_hold");
    enable = 1'b1;
    tick();
    run_start();
    run_draws(1'b0);

`ifdef SCROLL_PAUSE_EN
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_o("hold_paused", 0, 4'b0000, 1, 0, 0, 4'b0000, 3'b000, 3'd1, 3'd4);
    end
    pause = 1'b0;
    tick();
    chk_o("hold_resume", 0, 4'b0000, 1, 0, 0, 4'b0000, 3'b000, 3'd1, 3'd4);
    tick();
    pause = 1'b1;
    #1;
    chk_o("rst_upd_paused", 0, 4'b0000, 0, 0, 0, 4'b0000, 3'b000, 3'd5, 3'd5);
    finish_update = 1'b1;
    tick();
    finish_update = 1'b0;
    chk_o("rst_upd_still", 0, 4'b0000, 0, 0, 0, 4'b0000, 3'b000, 3'd5, 3'd5);
    pause = 1'b0;
    #1;
`else
    tick(); tick();
`endif

    // Update with same-cycle abort and finish_update on the last step.
    run_updates(1'b1);
    chk_idle("abort_vs_finish");
    chk("abort_no_frame_inc", 32'(frame_count), 32'd1);

    // Reset in DRAW with enable and finish_draw active.
    enable = 1'b1;
    tick();
    run_start();
    tick();
    reset = 1'b1;
    finish_draw = 4'b0001;
    tick();
    chk_idle("reset_mid_draw");
    chk("reset_mid_frame", 32'(frame_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
